// File: rtl/adder_8_pkg.sv
// Shared width and operand type for the registered ripple-carry adder.
package adder_8_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage

// File: rtl/adder_8_full_adder.sv
// Single-bit full-adder cell; the top chains WIDTH of these into a ripple adder.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ c;
  assign co = (x & y) | (c & (x ^ y));

endmodule

// File: rtl/adder_8.sv
// Ripple-carry adder with registered sum and carry-out, one cycle of latency.
module adder_8
  import adder_8_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_carry[0] = cin;

  // Carry ripples from bit 0 upward; the final carry is the WIDTH+1-th result bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .c  (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_carry[WIDTH];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_adder_8.sv
// Scoreboard bench for adder_8: expected {cout,sum} queued at drive time, compared one edge later.
module tb_adder_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  logic [8:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  adder_8 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  // Present operands on a falling edge and record the arithmetic result they must produce.
  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
    exp_q.push_back(9'(va) + 9'(vb) + 9'(vc));
  endtask

  task automatic test_reset();
    logic [8:0] e;
    rst = 1'b1;
    a   = 8'hA5;
    b   = 8'h3C;
    cin = 1'b1;
    #2;
    n_tests++;
    if ({cout, sum} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got %0d expected 0", {cout, sum});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({cout, sum} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %0d expected 0", {cout, sum});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(9'd226);
    @(posedge clk); #1;
    n_tests++;
    e = exp_q.pop_front();
    if ({cout, sum} !== e) begin
      n_fail++;
      $display("FAIL reset_release_load: got %0d expected %0d", {cout, sum}, e);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({cout, sum} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %0d expected 0", {cout, sum});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({cout, sum} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_async_hold: got %0d expected 0", {cout, sum});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Basic sums, carry wrap and extremes share one table.
  task automatic test_sums();
    logic [7:0] av [7] = '{8'd4,  8'd7,  8'd51, 8'd200, 8'd255, 8'd0, 8'd0};
    logic [7:0] bv [7] = '{8'd17, 8'd20, 8'd62, 8'd55,  8'd255, 8'd0, 8'd0};
    logic       cv [7] = '{1'b0,  1'b0,  1'b0,  1'b1,   1'b1,   1'b0, 1'b1};
    logic [8:0] rv [7] = '{9'd21, 9'd27, 9'd113, 9'd256, 9'd511, 9'd0, 9'd1};
    logic [8:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(av[i], bv[i], cv[i]);
      @(posedge clk); #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sums[%0d]: no queued result, got %0d", i, {cout, sum});
      end else begin
        e = exp_q.pop_front();
        if ({cout, sum} !== e || e !== rv[i]) begin
          n_fail++;
          $display("FAIL sums[%0d]: got sum=%0d cout=%0d expected %0d (table %0d)",
                   i, sum, cout, e, rv[i]);
        end
      end
    end
  endtask

  task automatic test_stability();
    logic [8:0] e;
    drive(8'd10, 8'd20, 1'b0);
    @(posedge clk); #1;
    n_tests++;
    e = exp_q.pop_front();
    if ({cout, sum} !== e) begin
      n_fail++;
      $display("FAIL stable_load: got %0d expected %0d", {cout, sum}, e);
    end
    #1;
    a   = 8'd100;
    b   = 8'd100;
    cin = 1'b1;
    #2;
    n_tests++;
    if ({cout, sum} !== 9'd30) begin
      n_fail++;
      $display("FAIL stable_midcycle: got %0d expected 30", {cout, sum});
    end
    exp_q.push_back(9'd201);
    @(posedge clk); #1;
    n_tests++;
    e = exp_q.pop_front();
    if ({cout, sum} !== e) begin
      n_fail++;
      $display("FAIL stable_next_edge: got %0d expected %0d", {cout, sum}, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    for (int i = 0; i < 10; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: no queued result, got %0d", i, {cout, sum});
      end else begin
        e = exp_q.pop_front();
        if ({cout, sum} !== e) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: a=%0d b=%0d cin=%0d got %0d expected %0d",
                   i, a, b, cin, {cout, sum}, e);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [8:0] e;
    drive(8'd30, 8'd40, 1'b0);
    @(posedge clk); #1;
    n_tests++;
    e = exp_q.pop_front();
    if ({cout, sum} !== e) begin
      n_fail++;
      $display("FAIL midreset_stream: got %0d expected %0d", {cout, sum}, e);
    end
    drive(8'd90, 8'd91, 1'b1);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({cout, sum} !== 9'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %0d expected 0", {cout, sum});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({cout, sum} !== 9'd0) begin
      n_fail++;
      $display("FAIL midreset_released_hold: got %0d expected 0", {cout, sum});
    end
    @(posedge clk); #1;
    n_tests++;
    e = exp_q.pop_front();
    if ({cout, sum} !== e) begin
      n_fail++;
      $display("FAIL midreset_first_edge: got %0d expected %0d", {cout, sum}, e);
    end
  endtask

  initial begin
    test_reset();
    test_sums();
    test_stability();
    test_back_to_back();
    test_midstream_reset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
